// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial feeder of the sequence-detector stage.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      GAP    = 2'd3
   } ser_state_t;

   localparam logic IDLE_BIT = 1'b0;

   // Counter must hold the larger of the data-bit and gap-bit run lengths.
   function automatic int unsigned cnt_width(input int unsigned width, input int unsigned gap);
      int unsigned m;
      m = (width > gap) ? width : gap;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel word to framed serial bit stream, one bit per external bit-rate strobe.
// Optional trailing even-parity bit is compiled in with SEQ_SER_PARITY_EN.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned GAP_BITS  = 2,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             bit_en,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             word_start,
   output logic             busy
);

   localparam int unsigned      CNT_W    = cnt_width(WIDTH, GAP_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = (GAP_BITS > 0) ? CNT_W'(GAP_BITS - 1) : '0;
   localparam ser_state_t       AFTER_WORD = ser_state_t'((GAP_BITS > 0) ? GAP : IDLE);
`ifdef SEQ_SER_PARITY_EN
   localparam ser_state_t       AFTER_DATA = PARITY;
`else
   localparam ser_state_t       AFTER_DATA = AFTER_WORD;
`endif

   ser_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             word_start_q, word_start_d;
   logic             busy_q, busy_d;
   logic             in_ready_q, in_ready_d;
   logic             head;
   logic [WIDTH-1:0] sr_shifted;
`ifdef SEQ_SER_PARITY_EN
   logic             par_q, par_d;
`endif

   // Head bit and post-shift register value for the configured bit order.
   always_comb begin
      if (MSB_FIRST != 0) begin
         head       = sr_q[WIDTH-1];
         sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
         head       = sr_q[0];
         sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sr_q         <= '0;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         word_start_q <= 1'b0;
         busy_q       <= 1'b0;
         in_ready_q   <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         word_start_q <= word_start_d;
         busy_q       <= busy_d;
         in_ready_q   <= in_ready_d;
`ifdef SEQ_SER_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      bit_out_d    = bit_out_q;
      bit_valid_d  = 1'b0;
      word_start_d = 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               sr_d    = in_data;
               cnt_d   = CNT_LAST;
               state_d = SHIFT;
`ifdef SEQ_SER_PARITY_EN
               par_d   = ^in_data;
`endif
            end
         end
         SHIFT: begin
            if (bit_en) begin
               bit_out_d    = head;
               bit_valid_d  = 1'b1;
               word_start_d = (cnt_q == CNT_LAST);
               sr_d         = sr_shifted;
               if (cnt_q == '0) begin
                  state_d = AFTER_DATA;
                  cnt_d   = (AFTER_DATA == GAP) ? GAP_LAST : '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
`ifdef SEQ_SER_PARITY_EN
         PARITY: begin
            if (bit_en) begin
               bit_out_d   = par_q;
               bit_valid_d = 1'b1;
               state_d     = AFTER_WORD;
               cnt_d       = (AFTER_WORD == GAP) ? GAP_LAST : '0;
            end
         end
`endif
         GAP: begin
            if (bit_en) begin
               bit_out_d   = IDLE_BIT;
               bit_valid_d = 1'b1;
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // Handshake and busy flags track the state being entered so they are registered.
      busy_d     = (state_d != IDLE);
      in_ready_d = (state_d == IDLE);
   end

   assign in_ready   = in_ready_q;
   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_valid_q;
   assign word_start = word_start_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first/gap-2 and LSB-first/gap-1 instances against a bit-list model.
module tb_seq_bit_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data0, in_data1;
   logic       in_valid0, in_valid1, bit_en0, bit_en1;
   logic       in_ready0, in_ready1, bit_out0, bit_out1;
   logic       bit_valid0, bit_valid1, word_start0, word_start1, busy0, busy1;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int period0 = 1;
   int period1 = 4;
   bit obs_b0[$], obs_w0[$], obs_b1[$], obs_w1[$];
   int obs_t1[$];
   bit exp_b[$], exp_w[$];
   logic prev_out0 = 1'b0, prev_out1 = 1'b0;
   bit   prev_rst = 1'b1;

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(8), .GAP_BITS(2), .MSB_FIRST(1)) u0 (
      .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
      .bit_en(bit_en0), .bit_out(bit_out0), .bit_valid(bit_valid0), .word_start(word_start0),
      .busy(busy0));

   seq_bit_serializer #(.WIDTH(8), .GAP_BITS(1), .MSB_FIRST(0)) u1 (
      .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .bit_en(bit_en1), .bit_out(bit_out1), .bit_valid(bit_valid1), .word_start(word_start1),
      .busy(busy1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: data bits in configured order, optional parity, then gap zeros.
   function automatic void add_word(input int k, input logic [7:0] d);
      int gap;
      gap = (k == 0) ? 2 : 1;
      for (int i = 0; i < 8; i++) begin
         exp_b.push_back((k == 0) ? d[7-i] : d[i]);
         exp_w.push_back(i == 0);
      end
`ifdef SEQ_SER_PARITY_EN
      exp_b.push_back(^d);
      exp_w.push_back(1'b0);
`endif
      for (int g = 0; g < gap; g++) begin
         exp_b.push_back(1'b0);
         exp_w.push_back(1'b0);
      end
   endfunction

   // One clock: sample at negedge, check hold, record bits, drive next strobes.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (!reset && !prev_rst) begin
         if (!bit_valid0) chk("hold0", bit_out0, prev_out0);
         if (!bit_valid1) chk("hold1", bit_out1, prev_out1);
      end
      if (bit_valid0) begin obs_b0.push_back(bit_out0); obs_w0.push_back(word_start0); end
      if (bit_valid1) begin
         obs_b1.push_back(bit_out1); obs_w1.push_back(word_start1); obs_t1.push_back(cyc);
      end
      prev_out0 = bit_out0;
      prev_out1 = bit_out1;
      prev_rst  = reset;
      bit_en0 = (cyc % period0) == 0;
      bit_en1 = (cyc % period1) == 0;
   endtask

   task automatic send(input int k, input logic [7:0] d, input bit keep_valid);
      if (k == 0) begin in_data0 = d; in_valid0 = 1'b1; end
      else begin in_data1 = d; in_valid1 = 1'b1; end
      for (int i = 0; i < 200; i++) begin
         if ((k == 0) ? in_ready0 : in_ready1) begin
            tick();
            if (!keep_valid) begin
               if (k == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
            end
            chk("busy_after_accept", (k == 0) ? busy0 : busy1, 1);
            chk("ready_low_after_accept", (k == 0) ? in_ready0 : in_ready1, 0);
            return;
         end
         tick();
      end
      chk("accept_timeout", (k == 0) ? in_ready0 : in_ready1, 1);
   endtask

   task automatic run_until(input int k, input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (((k == 0) ? obs_b0.size() : obs_b1.size()) >= n) return;
         tick();
      end
      chk("bits_timeout", (k == 0) ? obs_b0.size() : obs_b1.size(), n);
   endtask

   task automatic check_stream(input int k, input string tag);
      bit ob[$], ow[$];
      if (k == 0) begin ob = obs_b0; ow = obs_w0; obs_b0.delete(); obs_w0.delete(); end
      else begin ob = obs_b1; ow = obs_w1; obs_b1.delete(); obs_w1.delete(); end
      chk({tag, "_len"}, ob.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < ob.size(); i++) begin
         chk($sformatf("%s_bit%0d", tag, i), ob[i], exp_b[i]);
         chk($sformatf("%s_ws%0d", tag, i), ow[i], exp_w[i]);
      end
      exp_b.delete();
      exp_w.delete();
   endtask

   initial begin
      logic [7:0] d;
      reset = 1'b1;
      in_data0 = '0; in_data1 = '0; in_valid0 = 1'b0; in_valid1 = 1'b0;
      bit_en0 = 1'b0; bit_en1 = 1'b0;

      // Reset state and idle strobes.
      repeat (3) tick();
      chk("rst_bit_out", bit_out0, 0);
      chk("rst_bit_valid", bit_valid0, 0);
      chk("rst_word_start", word_start0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_in_ready", in_ready0, 0);
      reset = 1'b0;
      tick();
      chk("ready_after_release0", in_ready0, 1);
      chk("ready_after_release1", in_ready1, 1);
      chk("idle_busy", busy0, 0);
      repeat (10) tick();
      chk("idle_no_valid0", obs_b0.size(), 0);
      chk("idle_no_valid1", obs_b1.size(), 0);

      // A5 MSB-first, strobe every cycle, 2 gap bits.
      add_word(0, 8'hA5);
      send(0, 8'hA5, 1'b0);
      run_until(0, exp_b.size(), 100);
      check_stream(0, "a5");
      chk("ready_after_gap", in_ready0, 1);

      // 3C LSB-first, strobe every 4th clock.
      obs_t1.delete();
      add_word(1, 8'h3C);
      send(1, 8'h3C, 1'b0);
      run_until(1, exp_b.size(), 200);
      for (int i = 1; i < 8 && i < obs_t1.size(); i++)
         chk($sformatf("spacing%0d", i), obs_t1[i] - obs_t1[i-1], 4);
      check_stream(1, "3c");

      // Word whose parity is odd.
      add_word(0, 8'h07);
      send(0, 8'h07, 1'b0);
      run_until(0, exp_b.size(), 100);
      check_stream(0, "07");

      // Back-to-back with in_valid held high.
      add_word(0, 8'h81);
      add_word(0, 8'hFF);
      send(0, 8'h81, 1'b1);
      send(0, 8'hFF, 1'b0);
      run_until(0, exp_b.size(), 200);
      check_stream(0, "b2b");
      repeat (5) tick();
      chk("b2b_no_dup", obs_b0.size(), 0);

      // Reset mid-word, then a clean restart.
      send(0, 8'hF0, 1'b0);
      run_until(0, 3, 100);
      #2 reset = 1'b1;
      #1;
      chk("midrst_bit_out", bit_out0, 0);
      chk("midrst_bit_valid", bit_valid0, 0);
      chk("midrst_busy", busy0, 0);
      chk("midrst_in_ready", in_ready0, 0);
      repeat (2) tick();
      reset = 1'b0;
      obs_b0.delete(); obs_w0.delete();
      repeat (8) tick();
      chk("no_resume", obs_b0.size(), 0);
      chk("ready_after_midrst", in_ready0, 1);
      add_word(0, 8'h0F);
      send(0, 8'h0F, 1'b0);
      run_until(0, exp_b.size(), 100);
      check_stream(0, "0f");

      // Random words with random strobe rates on both instances.
      for (int n = 0; n < 6; n++) begin
         d = 8'($urandom);
         period0 = int'($urandom_range(3, 1));
         add_word(0, d);
         send(0, d, 1'b0);
         run_until(0, exp_b.size(), 300);
         check_stream(0, $sformatf("rnd0_%0d", n));
         d = 8'($urandom);
         period1 = int'($urandom_range(5, 1));
         add_word(1, d);
         send(1, d, 1'b0);
         run_until(1, exp_b.size(), 300);
         check_stream(1, $sformatf("rnd1_%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
